branch_trace_capture: RTL and testbench
=======================================

BRANCH_TRACE_CAPTURE -- requirements
Module: branch_trace_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning trace FIFO entries (power of two, 2..64).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port en_i, input, 1 bit: capture enable.
REQ-005 The block SHALL have port pc_i, input, 16 bits: CPU program counter, sampled every cycle.
REQ-006 The block SHALL have port clear_i, input, 1 bit: synchronous flush of FIFO and flags.
REQ-007 The block SHALL have port tr_valid_o, output, 1 bit: head entry available.
REQ-008 The block SHALL have port tr_ready_i, input, 1 bit: consumer accepts head entry.
REQ-009 The block SHALL have port tr_data_o, output, 32 bits: head entry {from_pc[31:16], to_pc[15:0]}.
REQ-010 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-011 The block SHALL have port overflow_o, output, 1 bit: sticky flag, an event was dropped.

Function
REQ-012 The block SHALL hold prev_pc and an armed bit; the first en_i=1 cycle after reset, clear_i or en_i low SHALL load prev_pc and set armed, with no event.
REQ-013 When armed and en_i=1, the block SHALL record an event when pc_i != prev_pc and pc_i != prev_pc+1 (mod 2^16).
REQ-014 A stall (pc_i == prev_pc) or sequential step SHALL produce no event; prev_pc SHALL update to pc_i every enabled cycle.
REQ-015 An event SHALL push {prev_pc, pc_i}, visible on tr_data_o with tr_valid_o=1 the cycle after the qualifying sample (latency 1) when the FIFO was empty.
REQ-016 The FIFO SHALL be first-word-fall-through: tr_valid_o = (count_o != 0); tr_data_o SHALL always show the oldest entry.
REQ-017 A pop SHALL occur on a rising edge with tr_valid_o & tr_ready_i; tr_data_o SHALL remain stable while tr_valid_o=1 and tr_ready_i=0.
REQ-018 Push and pop in the same cycle SHALL leave count_o unchanged, including when full.
REQ-019 A push when full without a simultaneous pop SHALL drop the new event, keep FIFO contents, and set overflow_o.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-021 clear_i SHALL take priority over push/pop: count_o=0, overflow_o=0, armed=0 on the next edge.
REQ-022 en_i=0 SHALL suppress events and clear armed; pops SHALL continue normally.

Reset
REQ-023 On reset: tr_valid_o=0, count_o=0, overflow_o=0, armed=0, prev_pc=0, pointers=0; tr_data_o SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard all FIFO contents immediately, without waiting for a clock edge.

Configuration
REQ-025 With macro TRACE_BKPT_EN defined, the block SHALL add inputs bkpt_en_i (1 bit) and bkpt_addr_i (16 bits), and output halt_o (1 bit, reset 0).
REQ-026 With TRACE_BKPT_EN, halt_o SHALL assert the cycle after a sample with en_i & bkpt_en_i & (pc_i == bkpt_addr_i), stay high until clear_i or reset, and while high suppress new events; an event on the matching sample itself SHALL be recorded.
REQ-027 Without TRACE_BKPT_EN, those ports and the logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-028 Sequential pc 0..5 then 35: exactly one entry, tr_data_o=0x00050023, count_o=1, tr_valid_o high one cycle after pc=35.
REQ-029 Stall: pc 10,10,10,11 -> no entries; then pc 60 -> entry 0x000B003C.
REQ-030 Fill: DEPTH=8, tr_ready_i=0, 9 branches -> count_o=8, overflow_o=1, 9th lost; drain returns the first 8 in order.
REQ-031 Full with simultaneous push and pop -> count_o stays 8, overflow_o stays 0, the new entry lands last.
REQ-032 Reset asserted asynchronously with count_o=3 -> count_o=0, tr_valid_o=0 before the next edge; the first post-reset pc produces no event.
REQ-033 TRACE_BKPT_EN, bkpt_addr_i=46: jump 35->46 recorded (0x0023002E), halt_o=1 next cycle, a later jump to 60 is not recorded, clear_i drops halt_o.

Source files
------------

// File: rtl/branch_trace_capture.sv
// Branch trace capture: records {from_pc, to_pc} on non-sequential PC changes into a FWFT FIFO.
// Optional breakpoint halt logic is built when TRACE_BKPT_EN is defined.
module branch_trace_capture #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset,
    input  logic                     en_i,
    input  logic [15:0]              pc_i,
    input  logic                     clear_i,
`ifdef TRACE_BKPT_EN
    input  logic                     bkpt_en_i,
    input  logic [15:0]              bkpt_addr_i,
    output logic                     halt_o,
`endif
    output logic                     tr_valid_o,
    input  logic                     tr_ready_i,
    output logic [31:0]              tr_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LP_PTR_ONE = AW'(1);
    localparam logic [AW:0]   LP_CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   LP_FULL    = (AW + 1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_armed;
    logic [15:0]   r_prev_pc;

    logic          w_branch;
    logic          w_event;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_halted;

`ifdef TRACE_BKPT_EN
    logic          r_halt;
    logic          w_bkpt_hit;

    assign w_bkpt_hit = en_i & bkpt_en_i & (pc_i == bkpt_addr_i);
    assign w_halted   = r_halt;
    assign halt_o     = r_halt;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_halt <= 1'b0;
        end else if (clear_i) begin
            r_halt <= 1'b0;
        end else if (w_bkpt_hit) begin
            r_halt <= 1'b1;
        end
    end
`else
    assign w_halted = 1'b0;
`endif

    // A stall or a +1 step is straight-line flow; anything else is a taken branch.
    assign w_branch = (pc_i != r_prev_pc) && (pc_i != (r_prev_pc + 16'd1));
    assign w_event  = en_i & r_armed & w_branch & ~w_halted & ~clear_i;
    assign w_full   = (r_count == LP_FULL);
    assign w_pop    = (r_count != '0) & tr_ready_i & ~clear_i;
    assign w_push   = w_event & (~w_full | w_pop);
    assign w_drop   = w_event & w_full & ~w_pop;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_prev_pc <= '0;
            r_armed   <= 1'b0;
        end else begin
            if (en_i) begin
                r_prev_pc <= pc_i;
            end
            r_armed <= en_i & ~clear_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; the empty check masks stale contents.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_prev_pc, pc_i};
        end
    end

    assign tr_valid_o = (r_count != '0);
    assign tr_data_o  = tr_valid_o ? r_mem[r_rptr] : 32'd0;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_branch_trace_capture.sv
// Directed-vector bench for branch_trace_capture (DEPTH=8).
// Breakpoint scenario is included when TRACE_BKPT_EN is defined.
module tb_branch_trace_capture;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        en_i = 1'b0;
    logic [15:0] pc_i = '0;
    logic        clear_i = 1'b0;
    logic        tr_valid_o;
    logic        tr_ready_i = 1'b0;
    logic [31:0] tr_data_o;
    logic [3:0]  count_o;
    logic        overflow_o;
`ifdef TRACE_BKPT_EN
    logic        bkpt_en_i = 1'b0;
    logic [15:0] bkpt_addr_i = '0;
    logic        halt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    branch_trace_capture #(.DEPTH(8)) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .en_i       (en_i),
        .pc_i       (pc_i),
        .clear_i    (clear_i),
`ifdef TRACE_BKPT_EN
        .bkpt_en_i  (bkpt_en_i),
        .bkpt_addr_i(bkpt_addr_i),
        .halt_o     (halt_o),
`endif
        .tr_valid_o (tr_valid_o),
        .tr_ready_i (tr_ready_i),
        .tr_data_o  (tr_data_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step(input logic e, input logic [15:0] p, input logic rdy);
        en_i = e;
        pc_i = p;
        tr_ready_i = rdy;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        n_vec++;
        if (count_o !== 4'd0 || tr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt got %0d/%b want 0/0", count_o, tr_valid_o);
        end
        n_vec++;
        if (tr_data_o !== 32'd0 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data got %h/%b want 0/0", tr_data_o, overflow_o);
        end
        reset = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_sequential;
        step(1'b1, 16'd0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0);
        n_vec++;
        if (count_o !== 4'd0) begin
            n_err++;
            $display("FAIL seq_noevent got %0d want 0", count_o);
        end
        step(1'b1, 16'd35, 1'b0);
        n_vec++;
        if (tr_valid_o !== 1'b1 || count_o !== 4'd1) begin
            n_err++;
            $display("FAIL seq_valid got %b/%0d want 1/1", tr_valid_o, count_o);
        end
        n_vec++;
        if (tr_data_o !== 32'h0005_0023) begin
            n_err++;
            $display("FAIL seq_data got %h want 00050023", tr_data_o);
        end
        step(1'b0, 16'd0, 1'b1);
        n_vec++;
        if (count_o !== 4'd0 || tr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL seq_pop got %0d/%b want 0/0", count_o, tr_valid_o);
        end
    endtask

    task automatic test_stall;
        step(1'b1, 16'd10, 1'b0);
        step(1'b1, 16'd10, 1'b0);
        step(1'b1, 16'd10, 1'b0);
        step(1'b1, 16'd11, 1'b0);
        n_vec++;
        if (count_o !== 4'd0) begin
            n_err++;
            $display("FAIL stall_none got %0d want 0", count_o);
        end
        step(1'b1, 16'd60, 1'b0);
        n_vec++;
        if (tr_data_o !== 32'h000B_003C || count_o !== 4'd1) begin
            n_err++;
            $display("FAIL stall_jump got %h/%0d want 000b003c/1", tr_data_o, count_o);
        end
        step(1'b0, 16'd0, 1'b1);
    endtask

    task automatic test_fill_overflow;
        logic [31:0] exp;
        step(1'b1, 16'h1000, 1'b0);
        for (int k = 2; k <= 9; k++) step(1'b1, 16'(k * 16'h1000), 1'b0);
        n_vec++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL fill_8 got %0d/%b want 8/0", count_o, overflow_o);
        end
        step(1'b1, 16'hA000, 1'b0);
        n_vec++;
        if (count_o !== 4'd8 || overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL fill_ovf got %0d/%b want 8/1", count_o, overflow_o);
        end
        n_vec++;
        if (tr_data_o !== 32'h1000_2000) begin
            n_err++;
            $display("FAIL fill_hold got %h want 10002000", tr_data_o);
        end
        for (int k = 1; k <= 8; k++) begin
            exp = {16'(k * 16'h1000), 16'((k + 1) * 16'h1000)};
            n_vec++;
            if (tr_data_o !== exp) begin
                n_err++;
                $display("FAIL drain_%0d got %h want %h", k, tr_data_o, exp);
            end
            step(1'b0, 16'd0, 1'b1);
        end
        n_vec++;
        if (count_o !== 4'd0 || overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL drain_end got %0d/%b want 0/1", count_o, overflow_o);
        end
        clear_i = 1'b1;
        step(1'b0, 16'd0, 1'b0);
        clear_i = 1'b0;
        n_vec++;
        if (overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ovf got %b want 0", overflow_o);
        end
    endtask

    task automatic test_full_push_pop;
        logic [31:0] exp;
        step(1'b1, 16'h1000, 1'b0);
        for (int k = 2; k <= 9; k++) step(1'b1, 16'(k * 16'h1000), 1'b0);
        step(1'b1, 16'hB000, 1'b1);
        n_vec++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL pp_full got %0d/%b want 8/0", count_o, overflow_o);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 7) exp = {16'((i + 2) * 16'h1000), 16'((i + 3) * 16'h1000)};
            else exp = 32'h9000_B000;
            n_vec++;
            if (tr_data_o !== exp) begin
                n_err++;
                $display("FAIL pp_drain_%0d got %h want %h", i, tr_data_o, exp);
            end
            step(1'b0, 16'd0, 1'b1);
        end
        n_vec++;
        if (count_o !== 4'd0) begin
            n_err++;
            $display("FAIL pp_end got %0d want 0", count_o);
        end
    endtask

    task automatic test_clear_priority;
        step(1'b1, 16'h1000, 1'b0);
        step(1'b1, 16'h3000, 1'b0);
        clear_i = 1'b1;
        step(1'b1, 16'h5000, 1'b1);
        clear_i = 1'b0;
        n_vec++;
        if (count_o !== 4'd0 || tr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL clr_prio got %0d/%b want 0/0", count_o, tr_valid_o);
        end
        step(1'b1, 16'h9000, 1'b0);
        n_vec++;
        if (count_o !== 4'd0) begin
            n_err++;
            $display("FAIL clr_rearm got %0d want 0", count_o);
        end
        step(1'b1, 16'h9100, 1'b0);
        n_vec++;
        if (count_o !== 4'd1 || tr_data_o !== 32'h9000_9100) begin
            n_err++;
            $display("FAIL clr_next got %0d/%h want 1/90009100", count_o, tr_data_o);
        end
    endtask

    task automatic test_async_reset;
        step(1'b1, 16'hA000, 1'b0);
        step(1'b1, 16'hC000, 1'b0);
        n_vec++;
        if (count_o !== 4'd3) begin
            n_err++;
            $display("FAIL ar_pre got %0d want 3", count_o);
        end
        en_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (count_o !== 4'd0 || tr_valid_o !== 1'b0 || tr_data_o !== 32'd0) begin
            n_err++;
            $display("FAIL ar_async got %0d/%b/%h want 0/0/0", count_o, tr_valid_o, tr_data_o);
        end
        #1 reset = 1'b0;
        @(negedge clk_i);
        step(1'b1, 16'h7000, 1'b0);
        n_vec++;
        if (count_o !== 4'd0) begin
            n_err++;
            $display("FAIL ar_first got %0d want 0", count_o);
        end
        step(1'b1, 16'h8000, 1'b0);
        n_vec++;
        if (count_o !== 4'd1 || tr_data_o !== 32'h7000_8000) begin
            n_err++;
            $display("FAIL ar_jump got %0d/%h want 1/70008000", count_o, tr_data_o);
        end
        clear_i = 1'b1;
        step(1'b0, 16'd0, 1'b0);
        clear_i = 1'b0;
    endtask

`ifdef TRACE_BKPT_EN
    task automatic test_bkpt;
        bkpt_en_i = 1'b1;
        bkpt_addr_i = 16'd46;
        step(1'b1, 16'd35, 1'b0);
        step(1'b1, 16'd46, 1'b0);
        n_vec++;
        if (halt_o !== 1'b1 || tr_data_o !== 32'h0023_002E) begin
            n_err++;
            $display("FAIL bk_hit got %b/%h want 1/0023002e", halt_o, tr_data_o);
        end
        step(1'b1, 16'd60, 1'b0);
        n_vec++;
        if (count_o !== 4'd1) begin
            n_err++;
            $display("FAIL bk_supp got %0d want 1", count_o);
        end
        bkpt_en_i = 1'b0;
        clear_i = 1'b1;
        step(1'b0, 16'd0, 1'b0);
        clear_i = 1'b0;
        n_vec++;
        if (halt_o !== 1'b0 || count_o !== 4'd0) begin
            n_err++;
            $display("FAIL bk_clr got %b/%0d want 0/0", halt_o, count_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_fill_overflow();
        test_full_push_pop();
        test_clear_priority();
        test_async_reset();
`ifdef TRACE_BKPT_EN
        test_bkpt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
